// File: rtl/hms_sevenseg_driver.sv
// Eight-digit multiplexed seven-segment driver showing a binary hour/min/sec time as "HH-MM-SS".
// Latency: an/seg/frame_start are registered one cycle behind the scan position; inputs captured at frame N are shown in frame N+1.
// Backpressure: none; the display is free-running, and the time inputs are sampled only at frame start.
module hms_sevenseg_driver #(
    parameter int SCAN_DIV = 12500
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [4:0] hour_in,
    input  logic [5:0] min_in,
    input  logic [5:0] sec_in,
    input  logic       blank,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       frame_start
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    // Any digit code above 9 renders as a dash; this one is used explicitly.
    localparam logic [3:0] DASH = 4'hF;

    // Scan position
    logic [DIV_W-1:0] div_cnt_q;
    logic [2:0]       digit_idx_q;
    logic             fs;

    // Snapshot of {hour, min, sec} taken at frame start, used for the range check
    logic [16:0]       snapshot_q;
    // Converter: per unit {bcd_tens, bcd_ones, binary}; unit 0 sec, 1 min, 2 hour
    logic [2:0][13:0]  conv_q;
    logic              conv_busy_q;
    logic [2:0]        conv_cnt_q;
    // Digit codes: 0 sec ones, 1 sec tens, 2 min ones, 3 min tens, 4 hr ones, 5 hr tens
    logic [5:0][3:0]   pending_q;
    logic [5:0][3:0]   display_q;
    logic [5:0][3:0]   commit_d;

    // Registered outputs
    logic [7:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       frame_start_q;

    assign fs          = (digit_idx_q == 3'd0) && (div_cnt_q == '0);
    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_start = frame_start_q;

    // One double-dabble step: add 3 to any BCD nibble >= 5, then shift the whole word left.
    function automatic logic [13:0] dd_step(input logic [13:0] v);
        logic [13:0] t;
        t = v;
        if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
        if (t[9:6] >= 4'd5)   t[9:6]   = t[9:6] + 4'd3;
        return {t[12:0], 1'b0};
    endfunction

    // Active-low {g,f,e,d,c,b,a} glyphs; codes above 9 give a dash (g only).
    function automatic logic [6:0] seg_of(input logic [3:0] code);
        case (code)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Scan counter: div_cnt wraps every SCAN_DIV cycles and advances the digit index.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            div_cnt_q   <= '0;
            digit_idx_q <= '0;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_q   <= '0;
            digit_idx_q <= digit_idx_q + 3'd1;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    // Range check applied to the finished BCD: an out-of-range field shows two dashes.
    always_comb begin
        commit_d[0] = (snapshot_q[5:0] > 6'd59)    ? DASH : conv_q[0][9:6];
        commit_d[1] = (snapshot_q[5:0] > 6'd59)    ? DASH : conv_q[0][13:10];
        commit_d[2] = (snapshot_q[11:6] > 6'd59)   ? DASH : conv_q[1][9:6];
        commit_d[3] = (snapshot_q[11:6] > 6'd59)   ? DASH : conv_q[1][13:10];
        commit_d[4] = (snapshot_q[16:12] > 5'd23)  ? DASH : conv_q[2][9:6];
        commit_d[5] = (snapshot_q[16:12] > 5'd23)  ? DASH : conv_q[2][13:10];
    end

    // Frame pipeline: at frame start promote pending to display and start converting a fresh snapshot;
    // six shift cycles follow, then one commit cycle writes pending well before the next frame.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            snapshot_q  <= '0;
            conv_q      <= '0;
            conv_busy_q <= 1'b0;
            conv_cnt_q  <= '0;
            pending_q   <= '0;
            display_q   <= '0;
        end else if (fs) begin
            display_q   <= pending_q;
            snapshot_q  <= {hour_in, min_in, sec_in};
            conv_q[0]   <= {8'd0, sec_in};
            conv_q[1]   <= {8'd0, min_in};
            conv_q[2]   <= {8'd0, 1'b0, hour_in};
            conv_busy_q <= 1'b1;
            conv_cnt_q  <= '0;
        end else if (conv_busy_q) begin
            if (conv_cnt_q == 3'd6) begin
                pending_q   <= commit_d;
                conv_busy_q <= 1'b0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    conv_q[i] <= dd_step(conv_q[i]);
                end
                conv_cnt_q <= conv_cnt_q + 3'd1;
            end
        end
    end

    // Output selection; at frame start display is being loaded from pending, so read pending
    // directly to keep the first cycle of digit 0 consistent with the rest of the frame.
    always_comb begin
        logic [5:0][3:0] src;
        logic [3:0]      code;
        src  = fs ? pending_q : display_q;
        code = DASH;
        case (digit_idx_q)
            3'd0:    code = src[0];
            3'd1:    code = src[1];
            3'd3:    code = src[2];
            3'd4:    code = src[3];
            3'd6:    code = src[4];
            3'd7:    code = src[5];
            default: code = DASH;
        endcase
        seg_d = seg_of(code);
        an_d  = blank ? 8'hFF : ~(8'd1 << digit_idx_q);
    end

    // Output registers
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            an_q          <= 8'hFF;
            seg_q         <= 7'h7F;
            frame_start_q <= 1'b0;
        end else begin
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= fs;
        end
    end

endmodule

// File: tb/tb_hms_sevenseg_driver.sv
// Bench for hms_sevenseg_driver with SCAN_DIV=16: a frame-level behavioural model checked every cycle,
// plus directed literal expectations for the stimulus scenarios.
module tb_hms_sevenseg_driver;
    localparam int SD    = 16;
    localparam int FRAME = 8 * SD;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic [4:0] hour_in;
    logic [5:0] min_in;
    logic [5:0] sec_in;
    logic       blank;
    logic [7:0] an;
    logic [6:0] seg;
    logic       frame_start;

    int compared   = 0;
    int mismatched = 0;

    hms_sevenseg_driver #(.SCAN_DIV(SD)) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .hour_in     (hour_in),
        .min_in      (min_in),
        .sec_in      (sec_in),
        .blank       (blank),
        .an          (an),
        .seg         (seg),
        .frame_start (frame_start)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // What digit position d must display for a frame showing time h:m:s.
    function automatic logic [6:0] model_seg(input int h, input int m, input int s, input int d);
        case (d)
            0: return (s > 59) ? 7'h3F : glyph(s % 10);
            1: return (s > 59) ? 7'h3F : glyph(s / 10);
            3: return (m > 59) ? 7'h3F : glyph(m % 10);
            4: return (m > 59) ? 7'h3F : glyph(m / 10);
            6: return (h > 23) ? 7'h3F : glyph(h % 10);
            7: return (h > 23) ? 7'h3F : glyph(h / 10);
            default: return 7'h3F;
        endcase
    endfunction

    // Model: k counts cycles since reset release; frame k/FRAME shows the time captured at the
    // start of the previous frame (zeros for the first frame after reset).
    int         mk     = 0;
    int         last_k = -1;
    bit         model_on = 0;
    int         snap_h = 0, snap_m = 0, snap_s = 0;
    int         show_h = 0, show_m = 0, show_s = 0;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_fs;

    initial forever begin
        @(posedge clk_100MHz);
        if (reset) begin
            model_on = 1;
            mk = 0; last_k = -1;
            snap_h = 0; snap_m = 0; snap_s = 0;
            show_h = 0; show_m = 0; show_s = 0;
            exp_an = 8'hFF; exp_seg = 7'h7F; exp_fs = 1'b0;
        end else if (model_on) begin
            int d;
            if (mk % FRAME == 0) begin
                show_h = snap_h; show_m = snap_m; show_s = snap_s;
                snap_h = int'(hour_in); snap_m = int'(min_in); snap_s = int'(sec_in);
            end
            d       = (mk % FRAME) / SD;
            exp_an  = blank ? 8'hFF : ~(8'd1 << d);
            exp_seg = model_seg(show_h, show_m, show_s, d);
            exp_fs  = (mk % FRAME == 0);
            last_k  = mk;
            mk++;
        end
        #1;
        if (model_on) begin
            check("cyc_an",  an, exp_an);
            check("cyc_seg", {1'b0, seg}, {1'b0, exp_seg});
            check("cyc_fs",  {7'b0, frame_start}, {7'b0, exp_fs});
        end
    end

    // Advance on falling edges until the outputs for cycle index target are visible.
    task automatic wait_k(input int target);
        for (int i = 0; i < 2000 && last_k != target; i++) @(negedge clk_100MHz);
        if (last_k != target) begin
            compared++;
            mismatched++;
            $display("FAIL wait_k: reached k=%0d, expected k=%0d", last_k, target);
        end
    endtask

    logic [7:0] an_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    // 13:45:07 -> digits 7,0,-,5,4,-,3,1
    logic [6:0] f2_tab  [8] = '{7'h78, 7'h40, 7'h3F, 7'h12, 7'h19, 7'h3F, 7'h30, 7'h79};
    // 24:60:59 -> digits 9,5 then dashes
    logic [6:0] bad_tab [8] = '{7'h10, 7'h12, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    initial begin
        reset = 1'b1; blank = 1'b0; hour_in = '0; min_in = '0; sec_in = '0;

        // Reset held for five cycles
        repeat (5) begin
            @(negedge clk_100MHz);
            check("rst_an",  an, 8'hFF);
            check("rst_seg", {1'b0, seg}, 8'h7F);
            check("rst_fs",  {7'b0, frame_start}, 8'h00);
        end

        // Release with 13:45:07; first frame shows zeros
        hour_in = 5'd13; min_in = 6'd45; sec_in = 6'd7; reset = 1'b0;
        wait_k(0);
        check("f1_fs_pulse", {7'b0, frame_start}, 8'h01);
        check("f1_d0_an", an, 8'hFE);
        check("f1_d0_seg", {1'b0, seg}, 8'h40);
        wait_k(1);
        check("f1_fs_low", {7'b0, frame_start}, 8'h00);
        wait_k(40);
        check("f1_d2_an", an, 8'hFB);
        check("f1_d2_seg", {1'b0, seg}, 8'h3F);

        // Second frame shows 13-45-07; seconds change while digit 3 is lit
        for (int d = 0; d < 8; d++) begin
            wait_k(FRAME + d * SD + 8);
            check($sformatf("f2_d%0d_an", d), an, an_tab[d]);
            check($sformatf("f2_d%0d_seg", d), {1'b0, seg}, {1'b0, f2_tab[d]});
            if (d == 3) sec_in = 6'd8;
        end
        wait_k(2 * FRAME + 8);
        check("f3_sec_ones", {1'b0, seg}, 8'h78);
        wait_k(3 * FRAME + 8);
        check("f4_sec_ones", {1'b0, seg}, 8'h00);
        wait_k(3 * FRAME + 24);
        check("f4_sec_tens", {1'b0, seg}, 8'h40);

        // Out-of-range hour and minute, captured at the start of frame 5, shown in frame 6
        hour_in = 5'd24; min_in = 6'd60; sec_in = 6'd59;
        wait_k(4 * FRAME + 8);
        check("f5_still_08", {1'b0, seg}, 8'h00);
        for (int d = 0; d < 8; d++) begin
            wait_k(5 * FRAME + d * SD + 4);
            check($sformatf("f6_d%0d_seg", d), {1'b0, seg}, {1'b0, bad_tab[d]});
        end

        // Free run: frame_start cadence
        wait_k(6 * FRAME);
        check("fs_k768", {7'b0, frame_start}, 8'h01);
        wait_k(6 * FRAME + 1);
        check("fs_k769", {7'b0, frame_start}, 8'h00);
        wait_k(7 * FRAME);
        check("fs_k896", {7'b0, frame_start}, 8'h01);

        // Reset during digit 5, then release with blank asserted
        wait_k(7 * FRAME + 5 * SD + 3);
        check("pre_rst_an", an, 8'hDF);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk_100MHz);
            check("mid_rst_an",  an, 8'hFF);
            check("mid_rst_seg", {1'b0, seg}, 8'h7F);
        end
        reset = 1'b0; blank = 1'b1;
        wait_k(0);
        check("blank_k0_an", an, 8'hFF);
        check("blank_k0_fs", {7'b0, frame_start}, 8'h01);
        wait_k(20);
        check("blank_k20_an", an, 8'hFF);
        wait_k(53);
        blank = 1'b0;
        wait_k(54);
        check("unblank_an",  an, 8'hF7);
        check("unblank_seg", {1'b0, seg}, 8'h40);
        wait_k(100);
        blank = 1'b1;
        wait_k(101);
        check("reblank_an", an, 8'hFF);
        wait_k(110);
        blank = 1'b0;
        wait_k(111);
        check("resume_an", an, 8'hBF);
        wait_k(FRAME + 8);
        check("post_rst_f2_seg", {1'b0, seg}, 8'h10);
        wait_k(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
